// File: rtl/hack_prog_loader.sv
// Byte-stream loader for length-prefixed Hack programs into instruction memory.
// Optional trailing 16-bit checksum check: define HACK_LOADER_CHECKSUM_EN.
module hack_prog_loader #(
  parameter int unsigned ADDR_WIDTH     = 15,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [7:0]            s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_wdata,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_written
);

  localparam int unsigned WW = ADDR_WIDTH + 1;
  localparam int unsigned CW = (ADDR_WIDTH + 1 > 17) ? ADDR_WIDTH + 1 : 17;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] DEPTH    = CW'(1) << ADDR_WIDTH;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_WRITE,
    S_DONE,
    S_ERROR
`ifdef HACK_LOADER_CHECKSUM_EN
    , S_CSUM_HI,
    S_CSUM_LO
`endif
  } state_t;

`ifdef HACK_LOADER_CHECKSUM_EN
  localparam state_t S_FINAL = S_CSUM_HI;
`else
  localparam state_t S_FINAL = S_DONE;
`endif

  state_t          state_q;
  state_t          state_nxt;
  logic [15:0]     len_q;
  logic [7:0]      hi_q;
  logic [TW-1:0]   tmo_q;
  logic            xfer;
  logic            tmo_hit;
  logic            tmo_wait;
  logic            can_start;
  logic            last_write;
  logic [15:0]     len_in;
  logic [15:0]     word_in;
`ifdef HACK_LOADER_CHECKSUM_EN
  logic [15:0]     sum_q;
`endif

  assign xfer       = s_valid && s_ready;
  assign tmo_hit    = (tmo_q == TMO_LAST);
  assign len_in     = {len_q[15:8], s_data};
  assign word_in    = {hi_q, s_data};
  assign last_write = (CW'(words_written) + CW'(1)) == CW'(len_q);
  assign can_start  = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR);
`ifdef HACK_LOADER_CHECKSUM_EN
  assign tmo_wait   = (state_q == S_LEN_LO) || (state_q == S_DATA_HI) ||
                      (state_q == S_DATA_LO) || (state_q == S_CSUM_HI) ||
                      (state_q == S_CSUM_LO);
`else
  assign tmo_wait   = (state_q == S_LEN_LO) || (state_q == S_DATA_HI) ||
                      (state_q == S_DATA_LO);
`endif

  // Next-state decode; waiting states fall to ERROR on an expired idle gap.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: if (start) state_nxt = S_LEN_HI;
      S_LEN_HI:                if (xfer) state_nxt = S_LEN_LO;
      S_LEN_LO: begin
        if (xfer) begin
          if (len_in == 16'd0)           state_nxt = S_FINAL;
          else if (CW'(len_in) > DEPTH)  state_nxt = S_ERROR;
          else                           state_nxt = S_DATA_HI;
        end else if (tmo_hit) begin
          state_nxt = S_ERROR;
        end
      end
      S_DATA_HI: begin
        if (xfer)         state_nxt = S_DATA_LO;
        else if (tmo_hit) state_nxt = S_ERROR;
      end
      S_DATA_LO: begin
        if (xfer)         state_nxt = S_WRITE;
        else if (tmo_hit) state_nxt = S_ERROR;
      end
      S_WRITE: state_nxt = last_write ? S_FINAL : S_DATA_HI;
`ifdef HACK_LOADER_CHECKSUM_EN
      S_CSUM_HI: begin
        if (xfer)         state_nxt = S_CSUM_LO;
        else if (tmo_hit) state_nxt = S_ERROR;
      end
      S_CSUM_LO: begin
        if (xfer)         state_nxt = (word_in == sum_q) ? S_DONE : S_ERROR;
        else if (tmo_hit) state_nxt = S_ERROR;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, datapath and status flags, all registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      s_ready       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      cpu_hold      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      words_written <= '0;
      len_q         <= '0;
      hi_q          <= '0;
      tmo_q         <= '0;
`ifdef HACK_LOADER_CHECKSUM_EN
      sum_q         <= '0;
`endif
    end else begin
      state_q  <= state_nxt;
      mem_we   <= (state_nxt == S_WRITE);
      busy     <= !((state_nxt == S_IDLE) || (state_nxt == S_DONE) || (state_nxt == S_ERROR));
      cpu_hold <= !((state_nxt == S_IDLE) || (state_nxt == S_DONE));
      done     <= (state_nxt == S_DONE);
      error    <= (state_nxt == S_ERROR);
`ifdef HACK_LOADER_CHECKSUM_EN
      s_ready  <= (state_nxt == S_LEN_HI) || (state_nxt == S_LEN_LO) ||
                  (state_nxt == S_DATA_HI) || (state_nxt == S_DATA_LO) ||
                  (state_nxt == S_CSUM_HI) || (state_nxt == S_CSUM_LO);
`else
      s_ready  <= (state_nxt == S_LEN_HI) || (state_nxt == S_LEN_LO) ||
                  (state_nxt == S_DATA_HI) || (state_nxt == S_DATA_LO);
`endif

      if (tmo_wait && !xfer) tmo_q <= tmo_q + TW'(1);
      else                   tmo_q <= '0;

      if (can_start && start) begin
        words_written <= '0;
        mem_addr      <= '0;
`ifdef HACK_LOADER_CHECKSUM_EN
        sum_q         <= '0;
`endif
      end

      if (xfer) begin
        case (state_q)
          S_LEN_HI:  len_q[15:8] <= s_data;
          S_LEN_LO:  len_q[7:0]  <= s_data;
          S_DATA_HI: hi_q        <= s_data;
          S_DATA_LO: begin
            mem_wdata <= word_in;
`ifdef HACK_LOADER_CHECKSUM_EN
            sum_q     <= sum_q + word_in;
`endif
          end
`ifdef HACK_LOADER_CHECKSUM_EN
          S_CSUM_HI: hi_q <= s_data;
`endif
          default: ;
        endcase
      end

      // Address saturates at the top word so a full-depth load never wraps.
      if (state_q == S_WRITE) begin
        words_written <= words_written + WW'(1);
        if (mem_addr != {ADDR_WIDTH{1'b1}}) mem_addr <= mem_addr + ADDR_WIDTH'(1);
      end
    end
  end

endmodule

// File: doc/hack_prog_loader.md
Name: hack_prog_loader

Overview:
- Byte-stream program loader: receives a length-prefixed Hack program and writes it word by word into the instruction memory's write port.
- Sits between a byte source (UART RX or similar, valid/ready) and the instruction BRAM.
- Holds the CPU in reset while a load is in progress or has failed.

Parameters:
- ADDR_WIDTH, 15, instruction memory address width; memory depth is 2**ADDR_WIDTH words.
- TIMEOUT_CYCLES, 1000000, max idle cycles between accepted bytes inside a frame before aborting; must be >= 1.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle pulse, begins a load
- s_data  input  8  incoming byte
- s_valid  input  1  s_data valid
- s_ready  output  1  loader accepts byte this cycle
- mem_we  output  1  instruction memory write enable, one cycle per word
- mem_addr  output  ADDR_WIDTH  write address
- mem_wdata  output  16  write data
- cpu_hold  output  1  1 = keep CPU in reset
- busy  output  1  load in progress
- done  output  1  sticky, last load completed OK
- error  output  1  sticky, last load aborted
- words_written  output  ADDR_WIDTH+1  words written in current/last load

Behaviour:
- Frame format: LEN_HI, LEN_LO (N = 16-bit word count, big-endian), then N words, each HI byte then LO byte.
- Byte transfer occurs when s_valid && s_ready.
- States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, DONE, ERROR (plus CSUM_HI, CSUM_LO with the optional feature).
- Reset (async, rst_n=0): state IDLE. All outputs 0: s_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, error, words_written. Timeout counter cleared.
- Reset mid-load: aborts immediately. Memory keeps any partially written words.
- IDLE/DONE/ERROR + start=1 -> LEN_HI next cycle. On that transition, clear done, error, words_written and mem_addr.
- start is ignored in every other state.
- s_ready=1 only in LEN_HI, LEN_LO, DATA_HI, DATA_LO (and CSUM_*); 0 elsewhere.
- LEN_LO accept:
  - N=0 -> DONE, no writes.
  - N > 2**ADDR_WIDTH -> ERROR.
  - Otherwise -> DATA_HI.
- DATA_HI accept: latch upper byte. DATA_LO accept: latch lower byte -> WRITE.
- WRITE lasts exactly one cycle:
  - mem_we=1, mem_addr = current address, mem_wdata = assembled word.
  - Next cycle: mem_addr+1, words_written+1.
  - If words_written reaches N -> DONE, otherwise -> DATA_HI.
  - Write latency: mem_we asserts the cycle after the LO byte is accepted.
- mem_addr never wraps, because N is capped at depth. At N = 2**ADDR_WIDTH, mem_addr saturates after the final write (held, not incremented).
- mem_we=0 in every state except WRITE. mem_wdata/mem_addr hold their last value otherwise.
- Timeout:
  - Counter increments each cycle in LEN_LO, DATA_HI, DATA_LO, CSUM_*.
  - Clears on any accepted byte and in all other states.
  - Reaching TIMEOUT_CYCLES -> ERROR.
  - LEN_HI waits indefinitely.
- busy=1 in all states except IDLE, DONE, ERROR.
- cpu_hold=1 in all states except IDLE and DONE, so it stays 1 in ERROR until a successful reload or reset.
- done=1 only in DONE; error=1 only in ERROR. Both remain asserted until the next start.
- A byte offered in the same cycle as the state transition out of WRITE is not accepted, because s_ready=0 during WRITE.

Optional Feature:
- Macro: HACK_LOADER_CHECKSUM_EN.
- Defined:
  - Loader keeps a 16-bit modulo-2^16 sum of all data words.
  - After the last WRITE (or after LEN_LO when N=0) go to CSUM_HI, CSUM_LO and receive the expected sum, big-endian.
  - Match -> DONE; mismatch -> ERROR.
  - The sum clears on start.
- Undefined: no checksum states; the last WRITE (or N=0) goes straight to DONE.

Test Plan:
- Reset then idle -> all outputs 0; s_ready=0; s_valid bytes ignored.
- start, bytes 00 02 EC 10 00 07 -> writes (addr0, 0xEC10), then (addr1, 0x0007), each 1-cycle mem_we. Then done=1, cpu_hold=0, words_written=2 (with CHECKSUM_EN, append EC 17 first).
- start, bytes 00 00 -> DONE with no mem_we pulse (with CHECKSUM_EN, append 00 00); bytes 80 01 -> ERROR, cpu_hold=1, no writes.
- start, 00 03, 1 word, then TIMEOUT_CYCLES idle cycles -> error=1 exactly at the limit, words_written=1; a second start with a valid frame -> clears error, ends done=1.
- s_valid held high continuously with a 4-word frame -> exactly 4 writes, one every 3 cycles. start pulsed mid-load has no effect. rst_n dropped mid-frame -> immediate IDLE, all outputs 0.
- CHECKSUM_EN: frame 00 01 12 34 then 12 35 -> ERROR; then 12 34 -> DONE.
